// File: rtl/lapido_hazard_ctrl.sv
// lapido_hazard_ctrl: scoreboarded hazard/forwarding controller for the LAPIDO core.
// Tracks destination registers of the DEPTH stages after ID and derives forwarding
// selects, load-use stall and branch flush for the instruction currently in ID.
module lapido_hazard_ctrl #(
    parameter int GPR_ADDR_WIDTH   = 5,
    parameter int DEPTH            = 3,
    parameter int ALU_READY_STAGE  = 1,
    parameter int LOAD_READY_STAGE = 2,
    parameter int BRANCH_STAGE     = 2,
    parameter int CNT_WIDTH        = 32,
    parameter int SEL_W            = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      hold,
    input  logic                      id_valid,
    input  logic [GPR_ADDR_WIDTH-1:0] id_rs,
    input  logic [GPR_ADDR_WIDTH-1:0] id_rt,
    input  logic                      id_uses_rs,
    input  logic                      id_uses_rt,
    input  logic                      id_reg_write,
    input  logic [GPR_ADDR_WIDTH-1:0] id_rd,
    input  logic                      id_is_load,
    input  logic                      branch_taken,
    output logic                      stall,
    output logic                      flush,
    output logic [SEL_W-1:0]          fwd_a,
    output logic [SEL_W-1:0]          fwd_b,
    output logic [CNT_WIDTH-1:0]      stall_count,
    output logic [CNT_WIDTH-1:0]      flush_count
);

    typedef struct packed {
        logic                      valid;
        logic                      we;
        logic                      is_load;
        logic [GPR_ADDR_WIDTH-1:0] rd;
    } entry_t;

    // Index k is the stage number: 1 = EX (youngest) ... DEPTH = WB (oldest).
    entry_t stage_q [1:DEPTH];
    entry_t stage_d [1:DEPTH];

    logic hit_a, hit_b;
    logic ready_a, ready_b;
    logic [SEL_W-1:0] sel_a, sel_b;
    logic hazard_a, hazard_b;

    // Find the youngest producer of each source; forward it only if it is ready.
    always_comb begin
        // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
        hit_a   = 1'b0;
        hit_b   = 1'b0;
        ready_a = 1'b0;
        ready_b = 1'b0;
        sel_a   = '0;
        sel_b   = '0;
        // Walk oldest to youngest so the youngest match overwrites older ones.
        for (int k = DEPTH; k >= 1; k--) begin
            if (id_uses_rs && stage_q[k].valid && stage_q[k].we &&
                stage_q[k].rd == id_rs && stage_q[k].rd != '0) begin
                hit_a   = 1'b1;
                ready_a = (k >= (stage_q[k].is_load ? LOAD_READY_STAGE : ALU_READY_STAGE));
                sel_a   = SEL_W'(k);
            end
            if (id_uses_rt && stage_q[k].valid && stage_q[k].we &&
                stage_q[k].rd == id_rt && stage_q[k].rd != '0) begin
                hit_b   = 1'b1;
                ready_b = (k >= (stage_q[k].is_load ? LOAD_READY_STAGE : ALU_READY_STAGE));
                sel_b   = SEL_W'(k);
            end
        end
        // A not-yet-ready youngest producer blocks forwarding from any older copy.
        hazard_a = hit_a && !ready_a;
        hazard_b = hit_b && !ready_b;
        fwd_a    = (hit_a && ready_a) ? sel_a : '0;
        fwd_b    = (hit_b && ready_b) ? sel_b : '0;
    end

    // A taken branch suppresses the stall: the ID instruction is being killed anyway.
    assign stall = id_valid && (hazard_a || hazard_b) && !branch_taken;
    assign flush = branch_taken && !hold;

    // Next scoreboard contents: shift, load stage 1, and kill wrong-path entries on flush.
    always_comb begin
        stage_d = stage_q;
        if (!hold) begin
            stage_d[1].valid   = id_valid && !stall && !branch_taken;
            stage_d[1].we      = id_reg_write;
            stage_d[1].is_load = id_is_load;
            stage_d[1].rd      = id_rd;
            for (int k = 2; k <= DEPTH; k++) begin
                stage_d[k] = stage_q[k-1];
            end
            // Entries landing in stages up to the branch are younger than it.
            if (flush) begin
                for (int k = 1; k <= BRANCH_STAGE; k++) begin
                    stage_d[k].valid = 1'b0;
                end
            end
        end
    end

    // Scoreboard register; reset clears the valid bits only.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: only the valid bits need a reset; payload fields are ignored while invalid.
            for (int k = 1; k <= DEPTH; k++) begin
                stage_q[k].valid <= 1'b0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all stages update together.
            stage_q <= stage_d;
        end
    end

    // Saturating profiling counters, frozen while hold is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
            flush_count <= '0;
        end else if (!hold) begin
            if (stall && stall_count != '1) stall_count <= stall_count + CNT_WIDTH'(1);
            if (flush && flush_count != '1) flush_count <= flush_count + CNT_WIDTH'(1);
        end
    end

endmodule
